uart_echo_ctrl: RTL and testbench

- Parametrised echo controller between the UART FIFO interface (rx_empty/r_data/rd_uart, tx_full/w_data/wr_uart) and board-level step/mode inputs.
- Replaces the fixed one-byte-per-button loopback with four modes: manual step, auto echo, counted burst, and XOR-transform echo.
- Drives a last-byte register for the LEDs and a running echo counter for the seven-segment status display.
- Sits beside the uart instance; its step input comes from the debounce db_tick.

---
 rtl/uart_echo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_echo_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_ctrl.sv
// rtl/uart_echo_ctrl.sv - UART echo controller with manual, auto, burst and XOR-transform modes
//
// Moves words from the UART RX FIFO to the UART TX FIFO one at a time. A
// four-state Moore FSM (IDLE -> RD -> WAIT_TX -> WR) issues exactly one pop
// and one push per word.
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-low
//   mode         00 manual, 01 auto, 10 burst, 11 transform
//   step         one-cycle debounced button tick
//   burst_len    words per burst (0 behaves as 1)
//   rx_empty     RX FIFO empty
//   r_data       RX FIFO head word, valid while rx_empty=0
//   tx_full      TX FIFO full
//   rd_uart      RX FIFO pop strobe (high only in RD)
//   wr_uart      TX FIFO push strobe (high only in WR)
//   w_data       word presented to the TX FIFO
//   last_byte    last word echoed, for the LEDs
//   echo_cnt     words echoed since reset, wraps
//   busy         FSM not in IDLE
//   burst_active burst in progress
module uart_echo_ctrl #(
    parameter int              DBIT    = 8,
    parameter int              CNT_W   = 16,
    parameter int              BURST_W = 4,
    parameter logic [DBIT-1:0] XMASK   = 8'h20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               step,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               rx_empty,
    input  logic [DBIT-1:0]    r_data,
    input  logic               tx_full,
    output logic               rd_uart,
    output logic               wr_uart,
    output logic [DBIT-1:0]    w_data,
    output logic [DBIT-1:0]    last_byte,
    output logic [CNT_W-1:0]   echo_cnt,
    output logic               busy,
    output logic               burst_active
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RD      = 2'b01,
        S_WAIT_TX = 2'b10,
        S_WR      = 2'b11
    } state_t;

    localparam logic [1:0] M_MANUAL = 2'b00;
    localparam logic [1:0] M_BURST  = 2'b10;
    localparam logic [1:0] M_XFORM  = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               pend_q, pend_d;
    logic               burst_active_q, burst_active_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [DBIT-1:0]    data_q, data_d;
    logic [DBIT-1:0]    last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               launch;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            mode_q         <= 2'b00;
            pend_q         <= 1'b0;
            burst_active_q <= 1'b0;
            burst_cnt_q    <= '0;
            data_q         <= '0;
            last_q         <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            pend_q         <= pend_d;
            burst_active_q <= burst_active_d;
            burst_cnt_q    <= burst_cnt_d;
            data_q         <= data_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        pend_d         = pend_q;
        burst_active_d = burst_active_q;
        burst_cnt_d    = burst_cnt_q;
        data_d         = data_q;
        last_d         = last_q;
        cnt_d          = cnt_q;

        // Launch depends on the mode latched in IDLE, so a word in flight
        // finishes under the mode it started with.
        case (mode_q)
            M_MANUAL: launch = pend_q | step;
            M_BURST:  launch = burst_active_q;
            default:  launch = 1'b1;
        endcase

        case (state_q)
            S_IDLE: begin
                mode_d = mode;
                if (launch && !rx_empty) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                data_d  = (mode_q == M_XFORM) ? (r_data ^ XMASK) : r_data;
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (!tx_full) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                last_d  = data_q;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_IDLE;
                if (burst_active_q) begin
                    burst_cnt_d = burst_cnt_q - BURST_W'(1);
                    if (burst_cnt_q == BURST_W'(1)) begin
                        burst_active_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One-deep step memory for manual mode; the step that launches a
        // read directly is consumed rather than pended.
        if (mode_q != M_MANUAL) begin
            pend_d = 1'b0;
        end else if (state_q == S_IDLE && state_d == S_RD) begin
            pend_d = 1'b0;
        end else if (step) begin
            pend_d = 1'b1;
        end

        if (mode_q != M_BURST) begin
            burst_active_d = 1'b0;
            burst_cnt_d    = '0;
        end else if (step && !burst_active_q) begin
            burst_active_d = 1'b1;
            burst_cnt_d    = (burst_len == '0) ? BURST_W'(1) : burst_len;
        end
    end

    assign rd_uart      = (state_q == S_RD);
    assign wr_uart      = (state_q == S_WR);
    assign busy         = (state_q != S_IDLE);
    assign w_data       = data_q;
    assign last_byte    = last_q;
    assign echo_cnt     = cnt_q;
    assign burst_active = burst_active_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb/tb_uart_echo_ctrl.sv - self-checking bench for uart_echo_ctrl
module tb_uart_echo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        step;
    logic [3:0]  burst_len;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        tx_full;

    logic        rd_uart, wr_uart, busy, burst_active;
    logic [7:0]  w_data, last_byte;
    logic [15:0] echo_cnt;

    logic        rd_uart4, wr_uart4, busy4, burst_active4;
    logic [7:0]  w_data4, last_byte4;
    logic [3:0]  echo_cnt4;

    always #5 clk = ~clk;

    uart_echo_ctrl dut (
        .clk(clk), .reset(reset), .mode(mode), .step(step), .burst_len(burst_len),
        .rx_empty(rx_empty), .r_data(r_data), .tx_full(tx_full),
        .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .last_byte(last_byte),
        .echo_cnt(echo_cnt), .busy(busy), .burst_active(burst_active)
    );

    uart_echo_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .mode(mode), .step(step), .burst_len(burst_len),
        .rx_empty(rx_empty), .r_data(r_data), .tx_full(tx_full),
        .rd_uart(rd_uart4), .wr_uart(wr_uart4), .w_data(w_data4), .last_byte(last_byte4),
        .echo_cnt(echo_cnt4), .busy(busy4), .burst_active(burst_active4)
    );

    int         checks = 0;
    int         errors = 0;
    int         n_wr = 0;
    int         n_rd = 0;
    int         exp_total = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync_rx();
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    task automatic push_word(input logic [7:0] w, input logic [7:0] echoed, input bit expect_it);
        rxq.push_back(w);
        if (expect_it) expq.push_back(echoed);
        sync_rx();
    endtask

    // One clock: RX FIFO pops on a sampled rd_uart, then strobes are checked
    // against the FIFO conditions and the expected echo stream.
    task automatic cyc();
        logic rd_before;
        logic txf_before;
        rd_before  = rd_uart;
        txf_before = tx_full;
        @(posedge clk);
        #1;
        if (rd_before === 1'b1 && rxq.size() != 0) void'(rxq.pop_front());
        sync_rx();
        if (rd_uart === 1'b1) begin
            n_rd++;
            chk("rd_nonempty", {31'b0, rx_empty}, 0);
        end
        if (wr_uart === 1'b1) begin
            n_wr++;
            chk("wr_not_full", {31'b0, txf_before}, 0);
            chk("wr_expected", {31'b0, expq.size() != 0}, 1);
            if (expq.size() != 0) chk("w_data", {24'b0, w_data}, {24'b0, expq.pop_front()});
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    task automatic drain(input int maxc, input bit rand_bp);
        int k = 0;
        while (expq.size() != 0 && k < maxc) begin
            if (rand_bp) tx_full = 1'($urandom_range(0, 1));
            cyc();
            k++;
        end
        tx_full = 1'b0;
        run(6);
        chk("drain_timeout", expq.size(), 0);
    endtask

    task automatic do_burst(input int len, input int nwords);
        int eff;
        int nexp;
        eff  = (len == 0) ? 1 : len;
        nexp = (nwords < eff) ? nwords : eff;
        mode = 2'b10;
        run(2);
        n_wr = 0;
        for (int i = 0; i < nwords; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            push_word(w, w, i < nexp);
        end
        burst_len = 4'(len);
        pulse_step();
        run(4 * eff + 10);
        chk("burst_count", n_wr, nexp);
        chk("burst_left", rxq.size(), nwords - nexp);
        chk("burst_active", {31'b0, burst_active}, {31'b0, nwords < eff});
        chk("burst_idle", {31'b0, busy}, 0);
        exp_total += nexp;
    endtask

    initial begin
        logic [7:0] w1, w2;

        reset = 1'b0; mode = 2'b01; step = 1'b0; burst_len = '0; tx_full = 1'b0;
        rxq.push_back(8'h99);
        sync_rx();
        repeat (3) begin
            cyc();
            chk("rst_rd", {31'b0, rd_uart}, 0);
            chk("rst_wr", {31'b0, wr_uart}, 0);
        end
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_burst", {31'b0, burst_active}, 0);
        chk("rst_wdata", {24'b0, w_data}, 0);
        chk("rst_last", {24'b0, last_byte}, 0);
        chk("rst_cnt", {16'b0, echo_cnt}, 0);
        chk("rst_cnt4", {28'b0, echo_cnt4}, 0);
        rxq.delete();
        sync_rx();
        reset = 1'b1;

        // Manual: second step while busy is pended, third is dropped.
        mode = 2'b00;
        run(3);
        n_wr = 0;
        push_word(8'h41, 8'h41, 1);
        push_word(8'h42, 8'h42, 1);
        push_word(8'h43, 8'h43, 0);
        pulse_step();
        chk("man_rd", {31'b0, rd_uart}, 1);
        pulse_step();
        chk("man_busy", {31'b0, busy}, 1);
        pulse_step();
        chk("man_wr", {31'b0, wr_uart}, 1);
        cyc();
        chk("man_last1", {24'b0, last_byte}, 32'h41);
        chk("man_cnt1", {16'b0, echo_cnt}, 1);
        run(14);
        chk("man_count", n_wr, 2);
        chk("man_left", rxq.size(), 1);
        chk("man_last2", {24'b0, last_byte}, 32'h42);
        exp_total = 2;
        chk("man_cnt2", {16'b0, echo_cnt}, exp_total);
        rxq.delete();
        sync_rx();

        // Auto with backpressure.
        mode = 2'b01;
        tx_full = 1'b1;
        n_wr = 0;
        n_rd = 0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            push_word(w, w, 1);
        end
        run(14);
        chk("auto_hold_wr", n_wr, 0);
        chk("auto_hold_rd", n_rd, 1);
        chk("auto_hold_busy", {31'b0, busy}, 1);
        drain(300, 1);
        chk("auto_rd", n_rd, 5);
        chk("auto_wr", n_wr, 5);
        exp_total += 5;
        chk("auto_cnt", {16'b0, echo_cnt}, exp_total);

        // Burst: nominal, zero length, random length, stall then complete.
        do_burst(3, 6);
        rxq.delete(); sync_rx();
        do_burst(0, 3);
        rxq.delete(); sync_rx();
        do_burst($urandom_range(1, 15), 17);
        rxq.delete(); sync_rx();
        do_burst(3, 2);
        w1 = 8'($urandom);
        push_word(w1, w1, 1);
        run(20);
        chk("stall_done", n_wr, 3);
        chk("stall_active", {31'b0, burst_active}, 0);
        exp_total += 1;
        chk("burst_cnt_total", {16'b0, echo_cnt}, exp_total);

        // Transform, then a mode switch while a word waits in WAIT_TX.
        mode = 2'b11;
        run(3);
        push_word(8'h61, 8'h41, 1);
        push_word(8'h5A, 8'h7A, 1);
        drain(60, 0);
        chk("xf_last", {24'b0, last_byte}, 32'h7A);
        exp_total += 2;
        tx_full = 1'b1;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        push_word(w1, w1 ^ 8'h20, 1);
        push_word(w2, w2, 1);
        run(4);
        chk("xf_wait", {31'b0, busy}, 1);
        mode = 2'b01;
        run(2);
        drain(60, 0);
        exp_total += 2;
        chk("xf_cnt", {16'b0, echo_cnt}, exp_total);

        // Reset while holding a word in WAIT_TX.
        tx_full = 1'b1;
        w1 = 8'($urandom);
        push_word(w1, w1, 0);
        run(4);
        chk("mid_busy", {31'b0, busy}, 1);
        reset = 1'b0;
        cyc();
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_cnt", {16'b0, echo_cnt}, 0);
        chk("mid_rst_wdata", {24'b0, w_data}, 0);
        reset = 1'b1;
        tx_full = 1'b0;
        n_wr = 0;
        run(10);
        chk("mid_no_wr", n_wr, 0);

        // Counter wrap on the 4-bit instance.
        for (int i = 0; i < 17; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            push_word(w, w, 1);
        end
        drain(600, 1);
        chk("wrap_cnt16", {16'b0, echo_cnt}, 17);
        chk("wrap_cnt4", {28'b0, echo_cnt4}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
